sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
- Round-robin scheduler sharing the single beamforming `sqrt` engine among N_REQ requesters (per-channel delay/distance units needing sqrt(dx²+dz²)).
- Accepts one 32-bit operand at a time and drives the engine with a one-cycle start pulse.
- Waits for the engine's valid, then returns the 16-bit root to the originating requester.
- Sits between the channel delay calculators and one `sqrt` instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 32, operand width.
- OW, 16, result width.
- TIMEOUT, 64, max WAIT cycles before abort (only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request; held until matching req_ack.
- req_din  in  N_REQ*DW  operands packed; slot i = bits [i*DW +: DW]; held while req[i]=1.
- req_ack  out  N_REQ  one-cycle pulse: operand of requester i accepted.
- res_valid  out  N_REQ  one-cycle pulse: res_dout belongs to requester i.
- res_dout  out  OW  shared result bus, valid only with a res_valid bit.
- eng_start  out  1  one-cycle start pulse to the sqrt engine.
- eng_din  out  DW  operand to engine, stable from eng_start until eng_valid.
- eng_valid  in  1  engine result valid.
- eng_dout  in  OW  engine result.
- busy  out  1  high in any state other than IDLE.
- error  out  1  sticky timeout flag; 0 without the optional feature.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - req_ack, res_valid, eng_start, busy, error all 0.
  - eng_din and res_dout are 0.
  - Reset mid-operation abandons the transaction: no res_valid is issued, and a later eng_valid is ignored.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If req≠0, grant the first set bit searching circularly from rr_ptr upward (rr_ptr, rr_ptr+1, …, wrap).
  - Latch grant index and operand into eng_din.
  - Next edge: state←ISSUE, req_ack[grant]←1, eng_start←1.
  - If req=0, stay in IDLE.
- ISSUE (1 cycle):
  - req_ack and eng_start high this cycle only.
  - Next edge: state←WAIT, pulses cleared.
- WAIT:
  - eng_din held.
  - On eng_valid=1: res_dout←eng_dout, res_valid[grant]←1 (one cycle), rr_ptr←(grant+1) mod N_REQ, state←IDLE.
  - eng_valid in the ISSUE cycle counts identically (zero-latency engine).
- eng_valid in IDLE is ignored: no res_valid, no state change.
- Latency:
  - req sampled at edge t → req_ack/eng_start high in cycle t+1.
  - eng_valid sampled at edge u → res_valid high in cycle u+1.
  - Minimum spacing between grants: req→ack 1 cycle, then one IDLE cycle after each result.
- Requester protocol:
  - req deasserted before ack means withdrawn; the arbiter never acks an unsampled request.
  - A requester may reassert req in the cycle after its ack. Round-robin places it lowest priority.
- Simultaneous requests: exactly one grant per transaction; no requester starves. Worst-case wait is N_REQ−1 transactions.
- Pointer wrap: grant=N_REQ−1 → rr_ptr=0.

Optional Feature:
- Macro: SQRT_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter cleared on ISSUE and incremented each WAIT cycle.
  - If it reaches TIMEOUT without eng_valid: res_valid[grant]←1 with res_dout={OW{1'b1}} (0xFFFF), error←1 (sticky until reset), rr_ptr advances, state←IDLE.
  - A late eng_valid is then ignored.
- Undefined: no counter; WAIT holds indefinitely; error tied to 0.

Test Plan:
- Single request: req=4'b0001, req_din[0]=144, engine model returns 12 after 5 cycles → req_ack=0001 one cycle, eng_start one cycle with eng_din=144, res_valid=0001, res_dout=12.
- Contention: req=4'b1111 held, operands 1, 4, 9, 16 → grants in order 0,1,2,3, results 1, 2, 3, 4; rr_ptr wraps to 0.
- Fairness: after grant 1, req=4'b0011 → next grant is 0 (search from 2 wraps past 3); requester 1 reasserting immediately is served after 0.
- Spurious/reset: eng_valid pulse in IDLE → no res_valid, busy stays 0. Assert reset_n=0 during WAIT → all outputs 0 immediately; a later eng_valid produces nothing.
- Timeout (SQRT_ARB_TIMEOUT_EN, TIMEOUT=64): engine never responds → res_valid on cycle 65 after ISSUE, res_dout=0xFFFF, error=1 sticky; next request is still served normally.
- Zero-latency engine: eng_valid asserted in the ISSUE cycle with eng_dout=7 → res_valid next cycle, res_dout=7, no hang.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt engine among N_REQ requesters.
// Optional macro SQRT_ARB_TIMEOUT_EN adds a WAIT-state timeout with a sticky error flag.
module sqrt_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned OW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   req_din,
  output logic [N_REQ-1:0]      req_ack,
  output logic [N_REQ-1:0]      res_valid,
  output logic [OW-1:0]         res_dout,
  output logic                  eng_start,
  output logic [DW-1:0]         eng_din,
  input  logic                  eng_valid,
  input  logic [OW-1:0]         eng_dout,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]  req_ack_q, req_ack_d;
  logic [N_REQ-1:0]  res_valid_q, res_valid_d;
  logic [OW-1:0]     res_dout_q, res_dout_d;
  logic              eng_start_q, eng_start_d;
  logic [DW-1:0]     eng_din_q, eng_din_d;
  logic              busy_q, busy_d;
  logic              finish;
  logic [PW-1:0]     rr_next;

  logic [DW-1:0]     din_arr [N_REQ];
  logic              found;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     idx;
  int unsigned       sum;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign din_arr[g] = req_din[g*DW +: DW];
  end

  // First set request searching circularly upward from rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    sum   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = 32'(rr_ptr_q) + i;
      idx = PW'(sum % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rr_next = (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);

`ifdef SQRT_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       error_q, error_d;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    req_ack_d   = '0;
    res_valid_d = '0;
    res_dout_d  = res_dout_q;
    eng_start_d = 1'b0;
    eng_din_d   = eng_din_q;
    finish      = 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    error_d     = error_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d         = StIssue;
          grant_d         = pick;
          req_ack_d[pick] = 1'b1;
          eng_start_d     = 1'b1;
          eng_din_d       = din_arr[pick];
        end
      end
      StIssue: begin
`ifdef SQRT_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        // A zero-latency engine may answer in the start cycle itself.
        if (eng_valid) begin
          res_dout_d = eng_dout;
          finish     = 1'b1;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (eng_valid) begin
          res_dout_d = eng_dout;
          finish     = 1'b1;
        end
`ifdef SQRT_ARB_TIMEOUT_EN
        else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          res_dout_d = '1;
          error_d    = 1'b1;
          finish     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
    if (finish) begin
      res_valid_d[grant_q] = 1'b1;
      rr_ptr_d             = rr_next;
      state_d              = StIdle;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      req_ack_q   <= '0;
      res_valid_q <= '0;
      res_dout_q  <= '0;
      eng_start_q <= 1'b0;
      eng_din_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      req_ack_q   <= req_ack_d;
      res_valid_q <= res_valid_d;
      res_dout_q  <= res_dout_d;
      eng_start_q <= eng_start_d;
      eng_din_q   <= eng_din_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign req_ack   = req_ack_q;
  assign res_valid = res_valid_q;
  assign res_dout  = res_dout_q;
  assign eng_start = eng_start_q;
  assign eng_din   = eng_din_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: directed scenarios plus randomized round-robin traffic
// checked against a transaction-level model with a bench-side integer sqrt engine.
module tb_sqrt_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_din;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    res_valid;
  logic [OW-1:0]   res_dout;
  logic            eng_start;
  logic [DW-1:0]   eng_din;
  logic            eng_valid;
  logic [OW-1:0]   eng_dout;
  logic            busy;
  logic            error;

  sqrt_arbiter #(.N_REQ(N), .DW(DW), .OW(OW), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_din   (req_din),
    .req_ack   (req_ack),
    .res_valid (res_valid),
    .res_dout  (res_dout),
    .eng_start (eng_start),
    .eng_din   (eng_din),
    .eng_valid (eng_valid),
    .eng_dout  (eng_dout),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          mptr   = 0;
  logic        exp_err = 1'b0;
  logic [DW-1:0] opnd [N];

  function automatic logic [OW-1:0] isqrt(input logic [DW-1:0] x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return OW'(r);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] v);
    req[i] = 1'b1;
    opnd[i] = v;
    for (int b = 0; b < DW; b++) req_din[i*DW + b] = v[b];
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 64'(req_ack), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_start"}, 64'(eng_start), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // One full transaction for expected grant g with engine latency lat (0 = answer in ISSUE).
  task automatic run_txn(input int g, input int lat);
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    tick();
    chk("grant_ack", 64'(req_ack), 64'(oh));
    chk("grant_start", 64'(eng_start), 64'(1));
    chk("grant_eng_din", 64'(eng_din), 64'(opnd[g]));
    chk("grant_busy", 64'(busy), 64'(1));
    chk("grant_no_res", 64'(res_valid), 64'(0));
    req[g] = 1'b0;
    if (lat > 0) begin
      tick();
      chk("wait_ack_clear", 64'(req_ack), 64'(0));
      chk("wait_start_clear", 64'(eng_start), 64'(0));
      chk("wait_busy", 64'(busy), 64'(1));
      for (int k = 1; k < lat; k++) tick();
      chk("wait_eng_din_held", 64'(eng_din), 64'(opnd[g]));
      chk("wait_no_res", 64'(res_valid), 64'(0));
    end
    eng_valid = 1'b1;
    eng_dout  = isqrt(opnd[g]);
    tick();
    eng_valid = 1'b0;
    eng_dout  = '0;
    chk("res_valid", 64'(res_valid), 64'(oh));
    chk("res_dout", 64'(res_dout), 64'(isqrt(opnd[g])));
    chk("res_busy", 64'(busy), 64'(0));
    chk("res_error", 64'(error), 64'(exp_err));
    mptr = (g + 1) % N;
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    req_din   = '0;
    eng_valid = 1'b0;
    eng_dout  = '0;
    for (int i = 0; i < N; i++) opnd[i] = '0;
    #12;
    chk_quiet("reset");
    chk("reset_eng_din", 64'(eng_din), 64'(0));
    chk("reset_res_dout", 64'(res_dout), 64'(0));
    chk("reset_error", 64'(error), 64'(0));
    #5 reset_n = 1'b1;
    tick();
    chk_quiet("idle_no_req");

    // Contention: all four hold requests, served 0,1,2,3 with roots 1..4.
    set_req(0, 1);
    set_req(1, 4);
    set_req(2, 9);
    set_req(3, 16);
    run_txn(0, 3);
    run_txn(1, 1);
    run_txn(2, 4);
    run_txn(3, 2);

    // Single request, 5-cycle engine.
    set_req(0, 144);
    run_txn(0, 5);

    // Fairness: after grant 1, requests 0 and 1 -> 0 first, then 1.
    set_req(1, 25);
    run_txn(1, 2);
    set_req(0, 36);
    set_req(1, 64);
    run_txn(0, 1);
    run_txn(1, 1);

    // Zero-latency engine.
    set_req(2, 49);
    run_txn(2, 0);

    // Spurious eng_valid in IDLE.
    eng_valid = 1'b1;
    eng_dout  = 16'h1234;
    tick();
    eng_valid = 1'b0;
    eng_dout  = '0;
    chk_quiet("spurious1");
    tick();
    chk_quiet("spurious2");

    // Reset during WAIT abandons the transaction.
    set_req(3, 100);
    tick();
    chk("rst_wait_ack", 64'(req_ack), 64'(4'b1000));
    req[3] = 1'b0;
    tick();
    tick();
    chk("rst_wait_busy", 64'(busy), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid_eng_din", 64'(eng_din), 64'(0));
    chk("rst_mid_res_dout", 64'(res_dout), 64'(0));
    #2 reset_n = 1'b1;
    mptr = 0;
    exp_err = 1'b0;
    eng_valid = 1'b1;
    eng_dout  = 16'd10;
    tick();
    eng_valid = 1'b0;
    eng_dout  = '0;
    chk_quiet("late_valid1");
    tick();
    chk_quiet("late_valid2");

`ifdef SQRT_ARB_TIMEOUT_EN
    // Engine never answers: abort on cycle 65 after ISSUE.
    set_req(1, 81);
    tick();
    chk("to_ack", 64'(req_ack), 64'(4'b0010));
    req[1] = 1'b0;
    for (int k = 0; k < 64; k++) tick();
    chk("to_not_yet", 64'(res_valid), 64'(0));
    tick();
    chk("to_res_valid", 64'(res_valid), 64'(4'b0010));
    chk("to_res_dout", 64'(res_dout), 64'(16'hFFFF));
    chk("to_error", 64'(error), 64'(1));
    exp_err = 1'b1;
    mptr = 2;
    eng_valid = 1'b1;
    tick();
    eng_valid = 1'b0;
    chk("to_late_ignored", 64'(res_valid), 64'(0));
    set_req(2, 121);
    run_txn(2, 3);
`endif

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 40; it++) begin
      int g;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(1, 0) == 1) set_req(i, $urandom);
      end
      if (req == '0) set_req($urandom_range(N - 1, 0), $urandom);
      g = rr_pick(req, mptr);
      run_txn(g, $urandom_range(6, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
